// File: rtl/gate_chk_pkg.sv
// gate_chk_pkg: shared types and constants for the gate bank checker.
//   - chk_state_e : checker FSM states
//   - GATE_*      : bit positions of each gate in the 6-bit gate vector
//   - exp_gates() : truth table of the two-input gate bank
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } chk_state_e;

  localparam int GATE_XOR  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_NOT  = 2;
  localparam int GATE_BUF  = 3;
  localparam int GATE_OR   = 4;
  localparam int GATE_NAND = 5;

  localparam int NUM_GATES   = 6;
  localparam int NUM_VECTORS = 4;

  function automatic logic [NUM_GATES-1:0] exp_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g            = '0;
    g[GATE_XOR]  = a ^ b;
    g[GATE_AND]  = a & b;
    g[GATE_NOT]  = ~a;
    g[GATE_BUF]  = a;
    g[GATE_OR]   = a | b;
    g[GATE_NAND] = ~(a & b);
    return g;
  endfunction

endpackage

// File: rtl/gate_chk_ref.sv
// gate_chk_ref: combinational golden model of the gate bank.
// Ports:
//   a_i, b_i : drive values currently applied to the gate bank
//   exp_o    : expected gate outputs, bit order as GATE_* in gate_chk_pkg
module gate_chk_ref
  import gate_chk_pkg::*;
(
  input  logic                 a_i,
  input  logic                 b_i,
  output logic [NUM_GATES-1:0] exp_o
);

  assign exp_o = exp_gates(a_i, b_i);

endmodule

// File: rtl/gate_bank_checker.sv
// gate_bank_checker: built-in self-test sequencer for the two-input gate bank.
// Steps a/b through all four combinations (a=idx[1], b=idx[0]), waits a
// settle time per vector, compares the six gate outputs against the golden
// model and accumulates sticky per-gate and per-vector failure masks.
//
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   start             : one-cycle run request, honoured only in IDLE
//   a_out, b_out      : registered drive to the gate bank inputs
//   xor_in .. nand_in : gate bank outputs under test
//   busy, done        : run in progress / one-cycle completion pulse
//   pass              : last completed run had no mismatches
//   fail_mask         : sticky per-gate mismatches [0]xor..[5]nand
//   fail_vec          : sticky per-vector mismatches, bit i = vector i
//   err_cnt           : (GATE_CHK_ERRCNT_EN only) mismatched gate-bits per run
//
// Optional feature macro: GATE_CHK_ERRCNT_EN
module gate_bank_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       xor_in,
  input  logic       and_in,
  input  logic       not_in,
  input  logic       buf_in,
  input  logic       or_in,
  input  logic       nand_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
`ifdef GATE_CHK_ERRCNT_EN
  output logic [4:0] err_cnt,
`endif
  output logic [3:0] fail_vec
);

  // A settle time of 0 would skip the wait entirely; clamp to one clock.
  localparam int               S_EFF    = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S_EFF - 1);

  chk_state_e             state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [NUM_GATES-1:0]   fail_mask_q, fail_mask_d;
  logic [NUM_VECTORS-1:0] fail_vec_q, fail_vec_d;

  logic [NUM_GATES-1:0]   gates_in;
  logic [NUM_GATES-1:0]   exp_vec;
  logic [NUM_GATES-1:0]   mism;

  // The drive is taken straight from the vector index register.
  assign a_out = idx_q[1];
  assign b_out = idx_q[0];

  assign gates_in[GATE_XOR]  = xor_in;
  assign gates_in[GATE_AND]  = and_in;
  assign gates_in[GATE_NOT]  = not_in;
  assign gates_in[GATE_BUF]  = buf_in;
  assign gates_in[GATE_OR]   = or_in;
  assign gates_in[GATE_NAND] = nand_in;

  gate_chk_ref u_ref (
    .a_i   (a_out),
    .b_i   (b_out),
    .exp_o (exp_vec)
  );

  // Case inequality so an X/Z gate output is flagged in simulation.
  always_comb begin
    mism = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      mism[i] = (gates_in[i] !== exp_vec[i]);
    end
  end

`ifdef GATE_CHK_ERRCNT_EN
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [2:0] mism_pop;

  always_comb begin
    mism_pop = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      mism_pop = mism_pop + {2'b00, mism[i]};
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == IDLE && start) begin
      err_cnt_d = '0;
    end else if (state_q == CHECK) begin
      err_cnt_d = err_cnt_q + {2'b00, mism_pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    fail_vec_d  = fail_vec_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          fail_mask_d = '0;
          fail_vec_d  = '0;
          pass_d      = 1'b0;
          idx_d       = 2'd0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        fail_mask_d = fail_mask_q | mism;
        if (|mism) begin
          fail_vec_d[idx_q] = 1'b1;
        end
        if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      DONE: begin
        // fail_mask_q already includes the final CHECK here.
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = ~|fail_mask_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
      fail_vec_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign fail_vec  = fail_vec_q;

endmodule

// File: doc/gate_bank_checker.md
Name: gate_bank_checker

Overview:
- Sequential stimulus driver and response checker for the two-input gate bank (xor/and/not/buf/or/nand outputs).
- Drives the bank's a/b inputs through all four combinations and waits a programmable settle time per combination.
- Samples the six gate outputs and compares them against the expected truth table.
- Reports a pass flag plus per-gate and per-vector failure masks. Used as the built-in self-test companion of the gate bank on the same clock.

Parameters:
- SETTLE_CYCLES, 2, clocks to wait after driving a vector before sampling; a value of 0 is treated as 1.
- CNT_W, 4, width of the internal settle counter; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to run a check; honoured only in IDLE
- a_out  out  1  registered drive to gate bank input a
- b_out  out  1  registered drive to gate bank input b
- xor_in  in  1  gate bank xor output
- and_in  in  1  gate bank and output
- not_in  in  1  gate bank not output (~a)
- buf_in  in  1  gate bank buffer output (a)
- or_in  in  1  gate bank or output
- nand_in  in  1  gate bank nand output
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when the check completes
- pass  out  1  1 when the completed run had zero mismatches; held until the next start
- fail_mask  out  6  sticky per-gate mismatch bits: [0]xor [1]and [2]not [3]buf [4]or [5]nand
- fail_vec  out  4  sticky per-vector mismatch bits; bit i corresponds to vector idx=i

Behaviour:
- Reset: rst is asynchronous and active-high. All outputs go to 0, state goes to IDLE, idx=0, cnt=0. Reset mid-run aborts the run; no done pulse is produced.
- Vector encoding: idx 0..3, with a_out=idx[1] and b_out=idx[0].
- Expected values: xor=a^b, and=a&b, not=~a, buf=a, or=a|b, nand=~(a&b), all computed from the registered a_out/b_out.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - On start: clear fail_mask, fail_vec and pass; set idx=0, a_out=0, b_out=0, cnt=0, busy=1; go to SETTLE.
  - Without start: hold all outputs.
- SETTLE: cnt increments each clock. When cnt==max(SETTLE_CYCLES,1)-1, go to CHECK.
- CHECK:
  - OR the per-gate mismatch vector into fail_mask. If any mismatch, set fail_vec[idx].
  - If idx==3, go to DONE.
  - Otherwise increment idx, update a_out/b_out, set cnt=0 and go to SETTLE.
- DONE: busy=0, done=1 for exactly one cycle; pass is set to ~|fail_mask, including this run's final CHECK. Return to IDLE.
- Latency: done is high N=4*(max(S,1)+1)+1 clocks after the start-accept edge. For S=2, N=13.
- start while busy or in DONE: ignored, with no effect on the run.
- An input that is X/Z at sample time counts as a mismatch (simulation).

Optional Feature:
- Macro GATE_CHK_ERRCNT_EN.
- When defined: adds output err_cnt[4:0], the total count of mismatched gate-bits over the run (0..24). It is cleared on start acceptance, incremented in CHECK by the popcount of the mismatch vector, held after done, and reset to 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Package gate_chk_pkg holds:
  - the state enum (IDLE, SETTLE, CHECK, DONE)
  - gate bit-index constants (GATE_XOR=0 .. GATE_NAND=5)
  - NUM_GATES=6 and NUM_VECTORS=4
  - function exp_gates(a,b), returning the 6-bit expected vector
- One sub-module, gate_chk_ref: a combinational golden model mapping a_out/b_out to the 6-bit expected vector. The checker instantiates it once.

Test Plan:
- Correct gate bank connected, S=2, pulse start → done at exactly 13 clocks, pass=1, fail_mask=6'b000000, fail_vec=4'b0000.
- nand_in stuck at 1 → pass=0, fail_mask=6'b100000, fail_vec=4'b1000; err_cnt=1 when GATE_CHK_ERRCNT_EN is defined.
- not_in wired to b_out instead of ~a → fail_mask=6'b000100, fail_vec=4'b1001.
- Assert rst during the third vector's SETTLE → all outputs 0 immediately with no done pulse. A new start then runs a full check, with done after 13 clocks.
- Second start pulse 5 clocks into a run → ignored; done still at clock 13, and only one done pulse.
- SETTLE_CYCLES=0 build → done at 9 clocks, with results identical to S=1.
